// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg: shared types and helpers for the counter scheduler.
//   mode_e  - per-job counting mode encoding (reserved code runs as mod-up)
//   state_e - scheduler FSM states
//   rr_pick - round-robin selection of the first request at/after a pointer
package ctr_sched_pkg;

    localparam int MAXREQ = 8;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Scans nreq slots starting at ptr, wrapping; returns the first set index.
    // Result is meaningless when no request is set; callers gate on |req.
    function automatic logic [2:0] rr_pick(input logic [MAXREQ-1:0] req,
                                           input logic [2:0] ptr,
                                           input int nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAXREQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (!found && (i < nreq) && req[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ctr_sched_if.sv
// ctr_sched_if: bundle between counter clients and the scheduler.
//   master - client side: drives req/mode/limit/len, observes grant and counter
//   slave  - scheduler side
//   req   [NREQ]      level job request per client
//   mode  [2*NREQ]    per-client mode, limit [CW*NREQ], len [LW*NREQ]
//   gnt   [NREQ]      one-hot grant, owner [IDW], busy, count [CW]
//   done  [NREQ]      one-cycle completion pulse
//   abort             one-cycle abort pulse (only with CTR_SCHED_ABORT_EN)
interface ctr_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 3,
    parameter int LW   = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  mode;
    logic [CW*NREQ-1:0] limit;
    logic [LW*NREQ-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     owner;
    logic               busy;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    done;
`ifdef CTR_SCHED_ABORT_EN
    logic               abort;
`endif

    modport master (
        output req, mode, limit, len,
`ifdef CTR_SCHED_ABORT_EN
        input  abort,
`endif
        input  gnt, owner, busy, count, done
    );

    modport slave (
        input  req, mode, limit, len,
`ifdef CTR_SCHED_ABORT_EN
        output abort,
`endif
        output gnt, owner, busy, count, done
    );
endinterface

// File: rtl/ctr_core.sv
// ctr_core: the single shared counter datapath.
//   clk, rst (async, active-high)
//   load  - clear count to 0 and set direction to up
//   en    - advance count one step according to mode/limit
//   mode  - MODE_UP / MODE_DOWN / MODE_TRI (reserved runs as MODE_UP)
//   limit - terminal / maximum value
//   count - current counter value
// Direction for triangle mode is kept internally.
module ctr_core
    import ctr_sched_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  mode_e         mode,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count
);

    logic          down_q;
    logic          down_nxt;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        down_nxt  = down_q;
        case (mode)
            MODE_DOWN: count_nxt = (count == '0) ? limit : count - 1'b1;
            MODE_TRI: begin
                if (limit == '0) begin
                    count_nxt = '0;
                end else if (!down_q) begin
                    if (count >= limit) begin
                        count_nxt = count - 1'b1;
                        down_nxt  = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end else begin
                    if (count == '0) begin
                        count_nxt = count + 1'b1;
                        down_nxt  = 1'b0;
                    end else begin
                        count_nxt = count - 1'b1;
                    end
                end
            end
            // Mod-up and the reserved code; limit at all-ones wraps naturally.
            default: count_nxt = (count >= limit) ? '0 : count + 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            count  <= '0;
            down_q <= 1'b0;
        end else if (en) begin
            count  <= count_nxt;
            down_q <= down_nxt;
        end
    end

endmodule

// File: rtl/ctr_sched.sv
// ctr_sched: round-robin scheduler sharing one counter among NREQ clients.
//   clk, rst (async, active-high)
//   bus (ctr_sched_if.slave): req/mode/limit/len in; gnt/owner/busy/count/done out
// Optional: CTR_SCHED_ABORT_EN - dropping req[owner] during RUN ends the job
// early with an abort pulse instead of done.
//
// state | meaning
// IDLE  | waiting; picks a winner and latches its job config
// LOAD  | clears counter, loads tick counter from latched length
// RUN   | counter advances once per cycle, grant held
// DONE  | completion pulse, pointer moves past the owner
module ctr_sched
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = 3,
    parameter int LW   = 8,
    parameter int IDW  = 2
) (
    input logic        clk,
    input logic        rst,
    ctr_sched_if.slave bus
);

    state_e            state;
    state_e            state_nxt;
    logic [IDW-1:0]    owner_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    pick;
    logic [MAXREQ-1:0] req_ext;
    logic [1:0]        pick_mode;
    logic [CW-1:0]     pick_limit;
    logic [LW-1:0]     pick_len;
    mode_e             job_mode;
    logic [CW-1:0]     job_limit;
    logic [LW-1:0]     job_len;
    logic [LW-1:0]     tick_q;
    logic [NREQ-1:0]   owner_1h;
    logic              last_tick;
`ifdef CTR_SCHED_ABORT_EN
    logic              abort_q;
`endif

    assign last_tick = (tick_q == LW'(1));
    assign owner_1h  = NREQ'(1) << owner_q;

    always_comb begin
        req_ext = '0;
        req_ext[NREQ-1:0] = bus.req;
        pick = IDW'(rr_pick(req_ext, 3'(ptr_q), NREQ));
        pick_mode  = '0;
        pick_limit = '0;
        pick_len   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == pick) begin
                pick_mode  = bus.mode[2*i +: 2];
                pick_limit = bus.limit[CW*i +: CW];
                pick_len   = bus.len[LW*i +: LW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.gnt   = '0;
        bus.busy  = 1'b0;
        bus.done  = '0;
        bus.owner = owner_q;
`ifdef CTR_SCHED_ABORT_EN
        bus.abort = 1'b0;
`endif
        case (state)
            IDLE: if (|bus.req) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN: begin
                bus.gnt  = owner_1h;
                bus.busy = 1'b1;
                if (last_tick) begin
                    state_nxt = DONE;
                end
`ifdef CTR_SCHED_ABORT_EN
                else if (!bus.req[owner_q]) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
`ifdef CTR_SCHED_ABORT_EN
                if (abort_q) bus.abort = 1'b1;
                else         bus.done  = owner_1h;
`else
                bus.done = owner_1h;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= '0;
            ptr_q     <= '0;
            job_mode  <= MODE_UP;
            job_limit <= '0;
            job_len   <= '0;
            tick_q    <= '0;
`ifdef CTR_SCHED_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner_q   <= pick;
                        job_mode  <= mode_e'(pick_mode);
                        job_limit <= pick_limit;
                        job_len   <= pick_len;
                    end
                end
                LOAD: begin
                    tick_q <= (job_len == '0) ? LW'(1) : job_len;
`ifdef CTR_SCHED_ABORT_EN
                    abort_q <= 1'b0;
`endif
                end
                RUN: begin
                    tick_q <= tick_q - 1'b1;
`ifdef CTR_SCHED_ABORT_EN
                    // A job finishing on this very cycle counts as completed.
                    if (!last_tick && !bus.req[owner_q]) abort_q <= 1'b1;
`endif
                end
                DONE: begin
                    ptr_q <= (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    ctr_core #(.CW(CW)) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (state == LOAD),
        .en    (state == RUN),
        .mode  (job_mode),
        .limit (job_limit),
        .count (bus.count)
    );

endmodule

// File: tb/tb_ctr_sched.sv
// tb_ctr_sched: randomized bench for ctr_sched with an arithmetic reference
// model (closed-form count sequences, queue-free round-robin pick).
module tb_ctr_sched;

    localparam int NREQ = 4;
    localparam int CW   = 3;
    localparam int LW   = 8;
    localparam int IDW  = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   ptr_m;
    int   cfg_mode  [NREQ];
    int   cfg_limit [NREQ];
    int   cfg_len   [NREQ];

    ctr_sched_if #(.NREQ(NREQ), .CW(CW), .LW(LW), .IDW(IDW)) bus ();

    ctr_sched #(.NREQ(NREQ), .CW(CW), .LW(LW), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Count value i steps after load, from the mode rules as closed forms.
    function automatic int exp_count(input int m, input int lim, input int i);
        int p;
        if (m == 1) return ((lim + 1) - (i % (lim + 1))) % (lim + 1);
        if (m == 2) begin
            if (lim == 0) return 0;
            p = i % (2 * lim);
            return (p <= lim) ? p : 2 * lim - p;
        end
        return i % (lim + 1);
    endfunction

    function automatic int exp_pick(input logic [NREQ-1:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic drive_cfg();
        for (int i = 0; i < NREQ; i++) begin
            bus.mode[2*i +: 2]    = 2'(cfg_mode[i]);
            bus.limit[CW*i +: CW] = CW'(cfg_limit[i]);
            bus.len[LW*i +: LW]   = LW'(cfg_len[i]);
        end
    endtask

    task automatic set_cfg(input int r, input int m, input int l, input int n);
        cfg_mode[r]  = m;
        cfg_limit[r] = l;
        cfg_len[r]   = n;
        drive_cfg();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    // Raise mask, serve every pending request in model order. A requester in
    // keep stays asserted after its first done and is served once more.
    task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] keep);
        logic [NREQ-1:0] pend;
        int exp, waited, m, l, n;
        @(negedge clk);
        drive_cfg();
        bus.req = mask;
        pend = mask;
        while (pend != 0) begin
            exp = exp_pick(pend, ptr_m);
            waited = 0;
            while (bus.gnt == '0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("grant_latency", 32'(waited), 32'd2);
            if (bus.gnt == '0) begin
                do_reset();
                return;
            end
            chk("gnt", 32'(bus.gnt), 32'(1 << exp));
            chk("owner", 32'(bus.owner), 32'(exp));
            chk("busy", 32'(bus.busy), 32'd1);
            chk("count_load", 32'(bus.count), 32'd0);
            m = cfg_mode[exp];
            l = cfg_limit[exp];
            n = (cfg_len[exp] == 0) ? 1 : cfg_len[exp];
            // Changing the owner's config mid-job must not affect it.
            set_cfg(exp, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 12));
            for (int i = 1; i <= n; i++) begin
                @(negedge clk);
                chk("count", 32'(bus.count), 32'(exp_count(m, l, i)));
                if (i < n) begin
                    chk("gnt_hold", 32'(bus.gnt), 32'(1 << exp));
                    chk("done_early", 32'(bus.done), 32'd0);
                end else begin
                    chk("done", 32'(bus.done), 32'(1 << exp));
                    chk("gnt_off", 32'(bus.gnt), 32'd0);
                    chk("busy_off", 32'(bus.busy), 32'd0);
                end
            end
            ptr_m = (exp + 1) % NREQ;
            if (keep[exp]) begin
                keep[exp] = 1'b0;
            end else begin
                pend[exp] = 1'b0;
                bus.req[exp] = 1'b0;
            end
            @(negedge clk);
            chk("done_pulse", 32'(bus.done), 32'd0);
            chk("count_hold", 32'(bus.count), 32'(exp_count(m, l, n)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ptr_m    = 0;
        rst      = 1'b1;
        bus.req  = '0;
        for (int i = 0; i < NREQ; i++) set_cfg(i, 0, 3, 2);
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // Contention from reset, then pointer favours 0 over re-asserted 1.
        run_batch(4'b1010, 4'b0000);
        run_batch(4'b0011, 4'b0000);

        set_cfg(0, 0, 4, 7);   run_batch(4'b0001, 4'b0000);
        set_cfg(0, 2, 3, 10);  run_batch(4'b0001, 4'b0000);
        set_cfg(0, 1, 5, 3);   run_batch(4'b0001, 4'b0000);
        set_cfg(0, 3, 2, 5);   run_batch(4'b0001, 4'b0000);
        set_cfg(0, 0, 3, 0);   run_batch(4'b0001, 4'b0000);
        set_cfg(0, 0, 7, 20);  run_batch(4'b0001, 4'b0000);
        set_cfg(0, 2, 0, 4);   run_batch(4'b0001, 4'b0000);
        set_cfg(0, 1, 0, 3);   run_batch(4'b0001, 4'b0000);
        set_cfg(1, 0, 7, 255); run_batch(4'b0010, 4'b0000);
        // Lone requester held after done is re-granted.
        set_cfg(2, 2, 2, 5);   run_batch(4'b0100, 4'b0100);

        // Reset in the middle of a job.
        set_cfg(2, 0, 7, 10);
        @(negedge clk);
        bus.req = 4'b0100;
        repeat (2) @(negedge clk);
        chk("mid_gnt_pre", 32'(bus.gnt), 32'b0100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus.done), 32'd0);
        end
        run_batch(4'b0110, 4'b0000);

        for (int b = 0; b < 25; b++) begin
            for (int r = 0; r < NREQ; r++) begin
                cfg_mode[r]  = $urandom_range(0, 3);
                cfg_limit[r] = $urandom_range(0, 7);
                cfg_len[r]   = $urandom_range(0, 12);
            end
            run_batch(NREQ'($urandom_range(1, 15)), NREQ'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
